// File: rtl/rom_ctrl_scan_reader.sv
// ROM scan reader: walks every ROM word once after start. Data words stream to
// KMAC through a one-entry buffer; the top NumDigestWords words are captured as
// the expected digest, then a one-cycle pulse starts the digest comparator.

package rom_ctrl_scan_reader_pkg;
  // Sparse state encoding, pairwise Hamming distance >= 3, Idle is all-zero.
  typedef enum logic [4:0] {
    StIdle       = 5'b00000,
    StReadData   = 5'b00111,
    StReadDigest = 5'b11001,
    StDone       = 5'b11110
  } state_e;
endpackage

module rom_ctrl_scan_reader
  import rom_ctrl_scan_reader_pkg::*;
#(
  parameter int unsigned RomDepth       = 16,
  parameter int unsigned NumDigestWords = 8,
  parameter int unsigned DataWidth      = 32,
  localparam int unsigned AW = (RomDepth > 1) ? $clog2(RomDepth) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  output logic                         rom_req_o,
  output logic [AW-1:0]                rom_addr_o,
  input  logic [DataWidth-1:0]         rom_rdata_i,
  output logic                         kmac_valid_o,
  output logic [DataWidth-1:0]         kmac_data_o,
  output logic                         kmac_last_o,
  input  logic                         kmac_ready_i,
  output logic [NumDigestWords*32-1:0] exp_digest_o,
  output logic                         cmp_start_o,
  output logic                         done_o,
  output logic                         alert_o,
  output logic [4:0]                   dbg_state_o
);

  localparam int unsigned  DataBase     = RomDepth - NumDigestWords;
  localparam logic [AW-1:0] DataBaseAddr = AW'(DataBase);
  localparam logic [AW-1:0] LastDataAddr = AW'(DataBase - 1);
  localparam logic [AW-1:0] LastAddr     = AW'(RomDepth - 1);

  // KMAC handshake: a word transfers in any cycle where kmac_valid_o and
  // kmac_ready_i are both high. Once kmac_valid_o rises it stays high and
  // kmac_data_o/kmac_last_o stay stable until that transfer happens.

  state_e                      state_q, state_d;
  logic [AW-1:0]               addr_q, addr_d;
  logic [AW-1:0]               addr_shadow_q, addr_shadow_d;
  logic                        req_prev_q, req_prev_d;
  logic [AW-1:0]               pend_addr_q, pend_addr_d;
  logic                        buf_valid_q, buf_valid_d;
  logic [DataWidth-1:0]        buf_data_q, buf_data_d;
  logic                        buf_last_q, buf_last_d;
  logic                        dig_req_done_q, dig_req_done_d;
  logic [NumDigestWords*32-1:0] digest_q, digest_d;
  logic                        cmp_sent_q, cmp_sent_d;

  logic rom_req;
  logic kmac_valid;
  logic kmac_fire;
  logic state_invalid;
  logic done;
  logic cnt_err;

  // Next-state, datapath updates and request generation.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    addr_shadow_d  = addr_shadow_q;
    req_prev_d     = 1'b0;
    pend_addr_d    = pend_addr_q;
    buf_valid_d    = buf_valid_q;
    buf_data_d     = buf_data_q;
    buf_last_d     = buf_last_q;
    dig_req_done_d = dig_req_done_q;
    digest_d       = digest_q;
    cmp_sent_d     = cmp_sent_q;
    rom_req        = 1'b0;
    kmac_valid     = 1'b0;
    kmac_fire      = 1'b0;
    state_invalid  = 1'b0;
    done           = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StReadData;
      end
      StReadData: begin
        kmac_valid = buf_valid_q;
        kmac_fire  = buf_valid_q && kmac_ready_i;
        // At most one read in flight, and only when its data has a free slot.
        rom_req    = !req_prev_q && (!buf_valid_q || kmac_fire) &&
                     (addr_q < DataBaseAddr);
        if (kmac_fire) begin
          buf_valid_d = 1'b0;
          if (buf_last_q) state_d = StReadDigest;
        end
        if (req_prev_q) begin
          buf_valid_d = 1'b1;
          buf_data_d  = rom_rdata_i;
          buf_last_d  = (pend_addr_q == LastDataAddr);
        end
      end
      StReadDigest: begin
        rom_req = !dig_req_done_q;
        for (int i = 0; i < int'(NumDigestWords); i++) begin
          if (req_prev_q && (pend_addr_q == AW'(DataBase + i))) begin
            digest_d[i*32 +: 32] = rom_rdata_i[31:0];
          end
        end
        // The final digest word is captured in this same cycle.
        if (dig_req_done_q) state_d = StDone;
      end
      StDone: begin
        done       = 1'b1;
        cmp_sent_d = 1'b1;
      end
      default: begin
        state_invalid = 1'b1;
      end
    endcase

    if (rom_req) begin
      req_prev_d  = 1'b1;
      pend_addr_d = addr_q;
      // The counter parks on the last address so Done can check it.
      if (addr_q != LastAddr) begin
        addr_d        = addr_q + 1'b1;
        addr_shadow_d = addr_shadow_q + 1'b1;
      end
      if ((state_q == StReadDigest) && (addr_q == LastAddr)) dig_req_done_d = 1'b1;
    end
  end

  // State and datapath registers; reset drops any outstanding ROM read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      addr_q         <= '0;
      addr_shadow_q  <= '0;
      req_prev_q     <= 1'b0;
      pend_addr_q    <= '0;
      buf_valid_q    <= 1'b0;
      buf_data_q     <= '0;
      buf_last_q     <= 1'b0;
      dig_req_done_q <= 1'b0;
      digest_q       <= '0;
      cmp_sent_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      addr_shadow_q  <= addr_shadow_d;
      req_prev_q     <= req_prev_d;
      pend_addr_q    <= pend_addr_d;
      buf_valid_q    <= buf_valid_d;
      buf_data_q     <= buf_data_d;
      buf_last_q     <= buf_last_d;
      dig_req_done_q <= dig_req_done_d;
      digest_q       <= digest_d;
      cmp_sent_q     <= cmp_sent_d;
    end
  end

  // Redundant counter copy: any divergence means the address counter was hit.
  assign cnt_err = (addr_q != addr_shadow_q);

  // Fault indication from state, counter and protocol consistency checks.
  always_comb begin
    alert_o = state_invalid
            | (start_i && (state_q != StIdle))
            | cnt_err
            | ((state_q == StIdle) && (addr_q != '0))
            | ((state_q == StDone) && (addr_q != LastAddr));
  end

  assign rom_req_o    = rom_req;
  assign rom_addr_o   = addr_q;
  assign kmac_valid_o = kmac_valid;
  assign kmac_data_o  = buf_data_q;
  assign kmac_last_o  = kmac_valid && buf_last_q;
  assign exp_digest_o = digest_q;
  assign cmp_start_o  = done && !cmp_sent_q;
  assign done_o       = done;
  assign dbg_state_o  = state_q;

endmodule
